// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: funct3 codes, FSM states,
// and helpers for access size and legality.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

  // Low two funct3 bits encode the size for both signed and unsigned loads.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
    end
    return (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Pipeline request/response and memory bus signals of the load/store master.
// Handshakes: a request transfers on a cycle where req_valid && req_ready; a bus
// beat transfers on a cycle where mem_req && mem_gnt; rsp_valid and mem_rvalid
// are single-cycle pulses with no back-pressure.
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, req_tag,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, req_tag,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from the two-word load buffer and sign- or
// zero-extends them according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] line,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = line[{off, 3'b000} +: 32];
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'b0, shifted[7:0]};
      F3_HU:   data = {16'b0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: takes one request at a time, issues one or two
// word-aligned byte-enabled bus beats, and returns a single tagged response.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  lsu_bus_master_if.master bus,
  output lsu_state_e       dbg_state
);

  lsu_state_e        state;
  lsu_state_e        next_state;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic [TAG_W-1:0]  tag_q;
  logic              err_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_q;

  logic              accept;
  logic [1:0]        off;
  logic [6:0]        be7;
  logic [63:0]       wd64;
  logic              need_beat1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       load_data;

  assign accept     = bus.req_valid && bus.req_ready;
  assign off        = addr_q[1:0];
  assign be7        = {3'b000, size_mask(funct3_q[1:0])} << off;
  assign wd64       = {32'b0, wdata_q} << {off, 3'b000};
  assign need_beat1 = |be7[6:4];
  assign addr0      = {addr_q[ADDR_W-1:2], 2'b00};
  assign addr1      = addr0 + ADDR_W'(4);
  assign dbg_state  = state;

  lsu_load_align u_align (
    .line   ({hi_q, lo_q}),
    .off    (off),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request fields and the load buffer; hi stays zero for single-beat loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
        tag_q    <= bus.req_tag;
        err_q    <= funct3_illegal(bus.req_we, bus.req_funct3);
        lo_q     <= '0;
        hi_q     <= '0;
      end
      if ((state == WAIT0) && bus.mem_rvalid) begin
        lo_q <= bus.mem_rdata;
      end
      if ((state == WAIT1) && bus.mem_rvalid) begin
        hi_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = funct3_illegal(bus.req_we, bus.req_funct3) ? RESP : ISSUE0;
        end
      end
      ISSUE0: begin
        if (bus.mem_gnt) begin
          if (!we_q)          next_state = WAIT0;
          else if (need_beat1) next_state = ISSUE1;
          else                next_state = RESP;
        end
      end
      WAIT0: begin
        if (bus.mem_rvalid) begin
          next_state = need_beat1 ? ISSUE1 : RESP;
        end
      end
      ISSUE1: begin
        if (bus.mem_gnt) begin
          next_state = we_q ? RESP : WAIT1;
        end
      end
      WAIT1: begin
        if (bus.mem_rvalid) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Bus and response outputs are decoded from state so reset clears them at once.
  always_comb begin
    bus.req_ready = (state == IDLE) && !rst;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_tag   = '0;
    bus.rsp_err   = 1'b0;
    case (state)
      ISSUE0: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr0;
        bus.mem_be    = be7[3:0];
        bus.mem_wdata = wd64[31:0];
      end
      ISSUE1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr1;
        bus.mem_be    = {1'b0, be7[6:4]};
        bus.mem_wdata = wd64[63:32];
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_tag   = tag_q;
        bus.rsp_err   = err_q;
        bus.rsp_data  = (we_q || err_q) ? 32'd0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed and random loads/stores against a
// byte-addressed reference memory, with a responsive bus slave model.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  lsu_state_e dbg_state;

  lsu_bus_master_if #(.ADDR_W(32), .TAG_W(5)) bus ();

  lsu_bus_master #(.ADDR_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [0:511];
  logic [31:0] bus_mem [0:127];
  logic [67:0] exp_q[$];   // {word addr, be, wdata} per expected beat
  logic [31:0] last_rsp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit model_illegal(input bit we, input logic [2:0] f3);
    if (we) return f3 > 3'd2;
    return (f3 == 3'd3) || (f3 >= 3'd6);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < size_bytes(f3); i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    for (int i = 0; i < size_bytes(f3); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
  endfunction

  // Beats come from the set of touched byte addresses grouped by word; each
  // lane carries the store-data byte that would land on that address.
  function automatic void plan_beats(input logic [31:0] addr, input logic [31:0] wdata, input int n);
    logic [31:0] w_addr [2];
    logic [3:0]  w_be [2];
    logic [31:0] a;
    logic [31:0] wd;
    int nb;
    int j;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (nb == 0 || w_addr[nb-1] != {a[31:2], 2'b00}) begin
        w_addr[nb] = {a[31:2], 2'b00};
        w_be[nb] = 4'b0000;
        nb++;
      end
      w_be[nb-1][a[1:0]] = 1'b1;
    end
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      wd = '0;
      for (int l = 0; l < 4; l++) begin
        j = int'(w_addr[b]) + l - int'(addr);
        if (j >= 0 && j < 4) wd[8*l +: 8] = wdata[8*j +: 8];
      end
      exp_q.push_back({w_addr[b], w_be[b], wd});
    end
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int l = 0; l < 4; l++) m[8*l +: 8] = be[l] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // ---------------- driver / bus slave ----------------
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [4:0] tag,
                         input int stall_lo, input int stall_hi, input int delay_hi, input bit spurious);
    bit          illegal;
    int          nbeats, exp_lat, cyc, beat_idx, stall_left, rd_delay;
    int          stalls [2];
    int          delays [2];
    bit          rd_pending, got_rsp;
    logic [31:0] exp_data, rd_addr;
    logic [3:0]  rd_be;
    logic [67:0] cur;

    illegal = model_illegal(we, f3);
    if (illegal) exp_q.delete();
    else plan_beats(addr, wdata, size_bytes(f3));
    nbeats  = exp_q.size();
    exp_lat = 1;
    for (int b = 0; b < nbeats; b++) begin
      stalls[b] = $urandom_range(stall_hi, stall_lo);
      delays[b] = $urandom_range(delay_hi, 0);
      exp_lat  += 1 + stalls[b] + (we ? 0 : 1 + delays[b]);
    end
    exp_data = (we || illegal) ? 32'd0 : model_load(addr, f3);

    @(negedge clk);
    check_eq("ready_in_idle", bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    bus.req_tag    = tag;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_tag    = 5'($urandom);

    cyc        = 1;
    beat_idx   = 0;
    stall_left = (nbeats > 0) ? stalls[0] : 0;
    rd_pending = 1'b0;
    rd_delay   = 0;
    rd_addr    = '0;
    rd_be      = '0;
    got_rsp    = 1'b0;
    while (!got_rsp && cyc < 100) begin
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (rd_pending) begin
        if (rd_delay == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = (bus_mem[rd_addr[8:2]] & be_mask(rd_be)) | ($urandom & ~be_mask(rd_be));
          rd_pending     = 1'b0;
        end else begin
          rd_delay--;
        end
      end
      if (bus.rsp_valid) begin
        got_rsp  = 1'b1;
        last_rsp = bus.rsp_data;
        check_eq("rsp_err", bus.rsp_err, illegal);
        check_eq("rsp_data", bus.rsp_data, exp_data);
        check_eq("rsp_tag", bus.rsp_tag, tag);
        check_eq("rsp_latency", cyc, exp_lat);
        check_eq("beats_used", beat_idx, nbeats);
        check_eq("req_in_resp", bus.mem_req, 1'b0);
      end else begin
        check_eq("busy_not_ready", bus.req_ready, 1'b0);
        if (bus.mem_req) begin
          if (beat_idx >= nbeats) begin
            check_eq("unexpected_mem_req", bus.mem_req, 1'b0);
          end else begin
            cur = exp_q[beat_idx];
            check_eq("beat_addr", bus.mem_addr, cur[67:36]);
            check_eq("beat_be", bus.mem_be, cur[35:32]);
            check_eq("beat_we", bus.mem_we, we);
            if (we) check_eq("beat_wdata", bus.mem_wdata, cur[31:0]);
            if (stall_left > 0) begin
              stall_left--;
              if (spurious && !rd_pending) bus.mem_rvalid = 1'b1;
            end else begin
              bus.mem_gnt = 1'b1;
              if (we) begin
                for (int l = 0; l < 4; l++)
                  if (bus.mem_be[l]) bus_mem[bus.mem_addr[8:2]][8*l +: 8] = bus.mem_wdata[8*l +: 8];
              end else begin
                rd_pending = 1'b1;
                rd_delay   = delays[beat_idx];
                rd_addr    = bus.mem_addr;
                rd_be      = bus.mem_be;
              end
              beat_idx++;
              if (beat_idx < nbeats) stall_left = stalls[beat_idx];
            end
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    check_eq("rsp_seen", got_rsp, 1'b1);
    check_eq("rsp_single_pulse", bus.rsp_valid, 1'b0);
    check_eq("ready_after_rsp", bus.req_ready, 1'b1);
    if (we && !illegal) model_store(addr, wdata, f3);
  endtask

  // Abort a word load by reset, either while requesting or while awaiting data.
  task automatic reset_abort(input bit in_wait);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h120;
    bus.req_funct3 = F3_W;
    bus.req_tag    = 5'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("abort_issue_req", bus.mem_req, 1'b1);
    if (in_wait) begin
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      check_eq("abort_wait_state", dbg_state, WAIT0);
    end
    #1 rst = 1'b1;
    #1;
    check_eq("abort_mem_req", bus.mem_req, 1'b0);
    check_eq("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("abort_ready_in_rst", bus.req_ready, 1'b0);
    check_eq("abort_state", dbg_state, IDLE);
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_no_rsp_rst", bus.rsp_valid, 1'b0);
    end
    rst = 1'b0;
    #1;
    check_eq("abort_ready_after", bus.req_ready, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_rsp", bus.rsp_valid, 1'b0);
      check_eq("abort_no_req", bus.mem_req, 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          we;
    logic [2:0]  legal_ld [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    bus.req_tag    = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    last_rsp       = '0;
    for (int b = 0; b < 512; b++) begin
      ref_mem[b] = 8'($urandom);
      bus_mem[b / 4][8*(b % 4) +: 8] = ref_mem[b];
    end

    #1;
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_be", bus.mem_be, 4'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_tag", bus.rsp_tag, 5'd0);
    check_eq("rst_rsp_err", bus.rsp_err, 1'b0);
    check_eq("rst_req_ready", bus.req_ready, 1'b0);
    check_eq("rst_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", bus.req_ready, 1'b1);

    // Directed cases
    run_txn(1'b1, 32'h100, 32'h1234_5678, F3_W, 5'd1, 0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h100, 32'h0, F3_W, 5'd2, 0, 0, 0, 1'b0);
    check_eq("lw_0x100", last_rsp, 32'h1234_5678);
    run_txn(1'b1, 32'h103, 32'h5566_77AA, F3_B, 5'd3, 0, 0, 0, 1'b0);
    run_txn(1'b1, 32'h103, 32'h0000_0080, F3_B, 5'd4, 0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h103, 32'h0, F3_B, 5'd5, 0, 0, 1, 1'b0);
    check_eq("lb_0x103", last_rsp, 32'hFFFF_FF80);
    run_txn(1'b0, 32'h103, 32'h0, F3_BU, 5'd6, 0, 0, 1, 1'b0);
    check_eq("lbu_0x103", last_rsp, 32'h0000_0080);
    run_txn(1'b1, 32'h100, 32'hBBAA_1111, F3_W, 5'd7, 0, 0, 0, 1'b0);
    run_txn(1'b1, 32'h104, 32'h2222_DDCC, F3_W, 5'd8, 0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h102, 32'h0, F3_W, 5'd9, 0, 1, 1, 1'b0);
    check_eq("lw_cross_0x102", last_rsp, 32'hDDCC_BBAA);
    run_txn(1'b1, 32'h101, 32'h0000_BEEF, F3_H, 5'd10, 3, 3, 0, 1'b1);
    run_txn(1'b0, 32'h101, 32'h0, F3_HU, 5'd11, 0, 0, 0, 1'b0);
    check_eq("lhu_0x101", last_rsp, 32'h0000_BEEF);
    run_txn(1'b0, 32'h103, 32'h0, F3_H, 5'd12, 1, 2, 2, 1'b1);
    run_txn(1'b0, 32'h110, 32'h0, 3'd3, 5'd13, 0, 0, 0, 1'b0);
    run_txn(1'b1, 32'h110, 32'hDEAD_BEEF, F3_BU, 5'd14, 0, 0, 0, 1'b0);
    reset_abort(1'b1);
    reset_abort(1'b0);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      we   = 1'($urandom_range(1, 0));
      addr = 32'h100 + 32'($urandom_range(32'hEF, 0));
      if ($urandom_range(9, 0) == 0) f3 = 3'($urandom_range(7, 0));
      else if (we) f3 = 3'($urandom_range(2, 0));
      else f3 = legal_ld[$urandom_range(4, 0)];
      run_txn(we, addr, $urandom, f3, 5'($urandom), 0, 3, 2, 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Initiator side of the data-memory load/store protocol.
- Accepts one load/store per handshake from the scoreboard pipeline and issues word-aligned, byte-enabled transactions on a req/gnt/rvalid memory bus.
- Splits accesses that cross a word boundary into two bus beats, then aligns and sign/zero-extends load data.
- Returns one tagged response per request so the scoreboard can retire it.

Parameters:
- ADDR_W, 32, address width; bit [1:0] is the byte offset.
- TAG_W, 5, width of the destination-register/scoreboard tag carried through.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- req_funct3  in  3  RV32 size/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- req_tag  in  TAG_W  tag returned with the response
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  extended load data; 0 for stores and errors
- rsp_tag  out  TAG_W  captured req_tag
- rsp_err  out  1  illegal funct3
- mem_req  out  1  bus request
- mem_gnt  in  1  bus accepted the current request
- mem_we  out  1  write
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - State IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_tag, rsp_err all 0.
  - req_ready = (state==IDLE) && !rst.
- FSM: IDLE -> ISSUE0 -> [WAIT0] -> [ISSUE1 -> WAIT1] -> RESP -> IDLE.
- IDLE:
  - On req_valid && req_ready, capture all request fields.
  - Illegal funct3 goes straight to RESP with rsp_err=1 and no bus access. Illegal codes: loads 3/6/7; stores any value other than 0/1/2.
  - All other requests go to ISSUE0.
- Lane math:
  - size_mask is 0001 (B), 0011 (H) or 1111 (W).
  - be7 = size_mask << off, a 7-bit value; off = addr[1:0].
  - wd64 = {32'b0, wdata} << (8*off).
  - Beat0: addr & ~3, be = be7[3:0], wdata = wd64[31:0].
  - Beat1 is needed iff be7[6:4] != 0. Beat1: addr0 + 4, be = {1'b0, be7[6:4]}, wdata = wd64[63:32].
- ISSUEn:
  - mem_req=1, with address/be/we/wdata held stable until the cycle mem_gnt=1.
  - On gnt: stores go to ISSUE1 if beat1 is needed and that beat is not yet issued, otherwise to RESP. Loads go to WAITn.
  - mem_req drops the cycle after gnt.
- WAITn:
  - mem_req=0. On mem_rvalid, latch mem_rdata into lo (beat0) or hi (beat1).
  - Next state: ISSUE1 if beat1 is needed, else RESP.
  - mem_rvalid arrives no earlier than the cycle after gnt.
- Load result:
  - r = ({hi, lo} >> 8*off)[31:0]; hi = 0 when there is no beat1.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- RESP: rsp_valid=1 for exactly one cycle with rsp_tag; next state IDLE. Stores respond with rsp_data=0.
- Latency, single beat, gnt in the first ISSUE cycle:
  - Load: accept T, mem_req T+1, rvalid T+2, rsp_valid T+3.
  - Store: rsp_valid T+2.
  - Each gnt stall cycle adds 1.
- Boundary rules:
  - mem_rvalid in IDLE/ISSUE/RESP is ignored.
  - req_valid outside IDLE is not accepted; the requester must hold it.
  - Reset mid-transaction aborts immediately: mem_req drops asynchronously and no response is issued.
  - off=3 with W produces 2 beats; off=3 with H produces 2 beats; off=1 or 2 with W produces 2 beats.

Decomposition:
- Shared package lsu_pkg contains:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The FSM state enum lsu_state_e.
  - A size_mask function.
  - An illegal-funct3 check function.
- One natural sub-module: lsu_load_align, a combinational shift plus sign/zero extend of the {hi, lo} buffer.

Test Plan:
- SW 0x1234_5678 @0x100, then LW @0x100, gnt immediate, rvalid next cycle -> beat at mem_addr 0x100 with be 1111; load returns rsp_data 0x12345678 at T+3 with the correct tag.
- SB 0x..AA @0x103 -> single beat, mem_addr 0x100, be 1000, mem_wdata 0xAA000000; rsp_valid with rsp_data 0.
- LB @0x103, mem_rdata 0x80xxxxxx -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
- LW @0x102, beat0 rdata 0xBBAA_xxxx, beat1 rdata 0xxxxx_DDCC -> beats (0x100, 1100) then (0x104, 0011); rsp_data 0xDDCCBBAA.
- SH @0x101 with gnt held low for 3 cycles -> mem_req, addr, be 0110 and wdata all stable for 4 cycles; exactly one gnt consumed.
- funct3=3 load -> rsp_err=1 and no mem_req. Separately, assert rst during WAIT0 -> mem_req=0 and no rsp_valid; after release req_ready=1.
